wall_lookup_arbiter: RTL

Shares the single read port of the combinational wall-map ROM (26 rows x 80 columns, 1 = wall) among N requesters: Pac-Man movement, ghost AI and the pellet/renderer checks. Each requester asks "is cell (row, col) a wall?" and receives a one-cycle response pulse carrying the hit bit. Arbitration is round-robin. The block sits between the game-logic agents and the wall ROM instance, and drives the ROM address directly.

---
 rtl/wall_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/wall_lookup_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/wall_pkg.sv
// Shared constants, FSM state type and ROM bit-select helper for the wall lookup arbiter.
package wall_pkg;

   localparam int unsigned ROWS  = 26;
   localparam int unsigned COLS  = 80;
   localparam int unsigned ROW_W = 5;
   localparam int unsigned COL_W = 7;

   typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;

   // Column 0 is the MSB (left screen edge); off-map columns read as wall.
   function automatic logic wall_bit(input logic [COLS-1:0] row_data,
                                     input logic [COL_W-1:0] col);
      logic [COL_W:0] idx;
      if (col >= COL_W'(COLS)) begin
         return 1'b1;
      end
      idx = (COL_W+1)'(COLS - 1) - {1'b0, col};
      return row_data[idx[COL_W-1:0]];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter  int unsigned N  = 5,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          grant_valid,
   output logic [IW-1:0] grant_idx
);

   logic [2*N-1:0] rotated;
   logic [IW:0]    sum;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      sum         = '0;
      rotated     = {req, req} >> ptr;
      for (int unsigned k = 0; k < N; k++) begin
         if (!grant_valid && rotated[k]) begin
            grant_valid = 1'b1;
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
               sum = sum - (IW+1)'(N);
            end
            grant_idx = sum[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/wall_lookup_arbiter.sv
// Round-robin sharing of the wall-map ROM read port; one lookup per three cycles.
module wall_lookup_arbiter
   import wall_pkg::*;
#(
   parameter  int unsigned N_REQ = 5,
   localparam int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*ROW_W-1:0] req_row,
   input  logic [N_REQ*COL_W-1:0] req_col,
   output logic [N_REQ-1:0]       resp_valid,
   output logic                   resp_hit,
   output logic                   busy,
   output logic [ROW_W-1:0]       rom_addr,
   input  logic [COLS-1:0]        rom_data
);

   state_e             state_q, state_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]      grant_q, grant_d;
   logic [ROW_W-1:0]   addr_q, addr_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
   logic               resp_hit_q, resp_hit_d;
   logic               arb_valid;
   logic [IW-1:0]      arb_idx;

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr_arbiter (
      .req         (req),
      .ptr         (rr_ptr_q),
      .grant_valid (arb_valid),
      .grant_idx   (arb_idx)
   );

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      addr_d       = addr_q;
      col_d        = col_q;
      resp_valid_d = '0;
      resp_hit_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               grant_d = arb_idx;
               addr_d  = req_row[arb_idx * ROW_W +: ROW_W];
               col_d   = req_col[arb_idx * COL_W +: COL_W];
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            // Off-map coordinates count as wall; ROM output is ignored for them.
            if (addr_q >= ROW_W'(ROWS) || col_q >= COL_W'(COLS)) begin
               resp_hit_d = 1'b1;
            end else begin
               resp_hit_d = wall_bit(rom_data, col_q);
            end
            for (int unsigned i = 0; i < N_REQ; i++) begin
               resp_valid_d[i] = (grant_q == IW'(i));
            end
            state_d = RESP;
         end
         RESP: begin
            rr_ptr_d = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         addr_q       <= '0;
         col_q        <= '0;
         resp_valid_q <= '0;
         resp_hit_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_q      <= grant_d;
         addr_q       <= addr_d;
         col_q        <= col_d;
         resp_valid_q <= resp_valid_d;
         resp_hit_q   <= resp_hit_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_hit   = resp_hit_q;
   assign rom_addr   = addr_q;
   assign busy       = (state_q != IDLE);

endmodule
